// File: rtl/dg_core_pkg.sv
// Shared definitions for the DG00xx core: op encoding and the polynomial PC successor.
package dg_core_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_JMP   = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_RETSK = 3'd5;
  localparam logic [2:0] OP_SETPG = 3'd6;

  // Right-shift LFSR with XNOR feedback; all-ones would lock up, so it escapes to 0.
  function automatic logic [31:0] dg_lfsr_next(input logic [31:0] pl, input int w);
    logic [31:0] mask;
    logic        fb;
    mask = (32'd1 << w) - 32'd1;
    fb   = ~(pl[0] ^ pl[1]);
    if ((pl & mask) == mask) return 32'd0;
    return ((pl & mask) >> 1) | ({31'd0, fb} << (w - 1));
  endfunction

endpackage

// File: rtl/dg_ret_stack.sv
// Return-address LIFO; entry count-1 is the top, slots above count are kept at zero.
module dg_ret_stack #(
  parameter int W        = 10,
  parameter int DEPTH    = 5,
  parameter int OVF_MODE = 0,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf_evt,
  output logic             unf_evt
);

  logic [W-1:0] ent [DEPTH];

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign ovf_evt = push & full;
  assign unf_evt = pop & empty;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(count) == i + 1) top = ent[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (push) begin
      if (!full) begin
        for (int i = 0; i < DEPTH; i++)
          if (int'(count) == i) ent[i] <= din;
        count <= count + CNT_W'(1);
      end else if (OVF_MODE == 0) begin
        // Full push slides everything down, dropping the oldest return address.
        for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
        ent[DEPTH-1] <= din;
      end
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH; i++)
        if (int'(count) == i + 1) ent[i] <= '0;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dg_pc_stack_unit.sv
// Program counter (LFSR low part + page) with page preload and a return stack.
module dg_pc_stack_unit
  import dg_core_pkg::*;
#(
  parameter int              PL_W      = 6,
  parameter int              PU_W      = 4,
  parameter int              DEPTH     = 5,
  parameter logic [PU_W-1:0] CALL_PAGE = '1,
  parameter int              OVF_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   op,
  input  logic [PL_W-1:0]              tgt_pl,
  input  logic [PU_W-1:0]              tgt_pu,
  input  logic                         clr_flags,
  output logic [PU_W+PL_W-1:0]         pc,
  output logic [PU_W+PL_W-1:0]         stk_top,
  output logic [$clog2(DEPTH+1)-1:0]   stk_count,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic                         ovf,
  output logic                         unf,
  output logic                         pg_pend
);

  localparam int W = PU_W + PL_W;

  logic [PL_W-1:0] pl, pl_succ, ret_succ;
  logic [PU_W-1:0] pu, pend_pu;
  logic            push, pop, ovf_evt, unf_evt;

  assign pc       = {pu, pl};
  assign push     = (op == OP_CALL);
  assign pop      = (op == OP_RET) || (op == OP_RETSK);
  assign pl_succ  = PL_W'(dg_lfsr_next(32'(pl), PL_W));
  // An empty stack peeks as zero, which is exactly the underflow return value.
  assign ret_succ = PL_W'(dg_lfsr_next(32'(stk_top[PL_W-1:0]), PL_W));

  dg_ret_stack #(.W(W), .DEPTH(DEPTH), .OVF_MODE(OVF_MODE)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     ({pu, pl_succ}),
    .top     (stk_top),
    .count   (stk_count),
    .full    (stk_full),
    .empty   (stk_empty),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl      <= '0;
      pu      <= '0;
      pend_pu <= '0;
      pg_pend <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      case (op)
        OP_INC:   pl <= pl_succ;
        OP_JMP: begin
          pl <= tgt_pl;
          if (pg_pend) pu <= pend_pu;
        end
        OP_CALL: begin
          pl <= tgt_pl;
          pu <= pg_pend ? pend_pu : CALL_PAGE;
        end
        OP_RET: begin
          pu <= stk_top[W-1:PL_W];
          pl <= stk_top[PL_W-1:0];
        end
        OP_RETSK: begin
          pu <= stk_top[W-1:PL_W];
          pl <= ret_succ;
        end
        OP_SETPG: if (!pg_pend) pend_pu <= tgt_pu;
        default: ;
      endcase
      // The preload lives for exactly one following op; repeated SETPG keeps the first page.
      pg_pend <= (op == OP_SETPG);
      ovf     <= ovf_evt | (ovf & ~clr_flags);
      unf     <= unf_evt | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_dg_pc_stack_unit.sv
// Runs both overflow policies in lockstep against a queue-based reference model.
module tb_dg_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] op;
  logic [5:0] tgt_pl;
  logic [3:0] tgt_pu;
  logic       clr_flags;

  logic [9:0] pc_w [2];
  logic [9:0] top_w [2];
  logic [2:0] cnt_w [2];
  logic       full_w [2], empty_w [2], ovf_w [2], unf_w [2], pend_w [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dg_pc_stack_unit #(.OVF_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .clr_flags(clr_flags), .pc(pc_w[0]), .stk_top(top_w[0]), .stk_count(cnt_w[0]),
    .stk_full(full_w[0]), .stk_empty(empty_w[0]), .ovf(ovf_w[0]), .unf(unf_w[0]),
    .pg_pend(pend_w[0]));

  dg_pc_stack_unit #(.OVF_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .clr_flags(clr_flags), .pc(pc_w[1]), .stk_top(top_w[1]), .stk_count(cnt_w[1]),
    .stk_full(full_w[1]), .stk_empty(empty_w[1]), .ovf(ovf_w[1]), .unf(unf_w[1]),
    .pg_pend(pend_w[1]));

  // Reference model: PC as two fields, stack as a queue (back = top).
  logic [5:0] m_pl [2];
  logic [3:0] m_pu [2];
  logic [9:0] mq [2][$];
  logic       m_ovf [2], m_unf [2];
  logic       m_pend;
  logic [3:0] m_ppu;

  function automatic logic [5:0] nxt(input logic [5:0] p);
    if (p == 6'h3f) return 6'h00;
    return (p >> 1) + ((p[0] == p[1]) ? 6'h20 : 6'h00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    for (int m = 0; m < 2; m++) begin
      m_pl[m] = '0; m_pu[m] = '0; m_ovf[m] = 0; m_unf[m] = 0;
      mq[m].delete();
    end
    m_pend = 0; m_ppu = '0;
  endtask

  task automatic model_op(input logic [2:0] o, input logic [5:0] tpl,
                          input logic [3:0] tpu, input logic clr);
    logic [9:0] v;
    logic oe, ue;
    for (int m = 0; m < 2; m++) begin
      oe = 0; ue = 0;
      case (o)
        3'd1: m_pl[m] = nxt(m_pl[m]);
        3'd2: begin m_pl[m] = tpl; if (m_pend) m_pu[m] = m_ppu; end
        3'd3: begin
          v = {m_pu[m], nxt(m_pl[m])};
          if (mq[m].size() < 5) mq[m].push_back(v);
          else begin
            oe = 1;
            if (m == 0) begin void'(mq[m].pop_front()); mq[m].push_back(v); end
          end
          m_pl[m] = tpl;
          m_pu[m] = m_pend ? m_ppu : 4'hF;
        end
        3'd4, 3'd5: begin
          if (mq[m].size() == 0) begin v = '0; ue = 1; end
          else v = mq[m].pop_back();
          m_pu[m] = v[9:6];
          m_pl[m] = (o == 3'd5) ? nxt(v[5:0]) : v[5:0];
        end
        default: ;
      endcase
      m_ovf[m] = oe | (m_ovf[m] & ~clr);
      m_unf[m] = ue | (m_unf[m] & ~clr);
    end
    if (o == 3'd6) begin
      if (!m_pend) m_ppu = tpu;
      m_pend = 1;
    end else m_pend = 0;
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.m%0d.pc", tag, m), 32'(pc_w[m]), 32'({m_pu[m], m_pl[m]}));
      chk($sformatf("%s.m%0d.top", tag, m), 32'(top_w[m]),
          (mq[m].size() != 0) ? 32'(mq[m][$]) : 32'd0);
      chk($sformatf("%s.m%0d.cnt", tag, m), 32'(cnt_w[m]), 32'(mq[m].size()));
      chk($sformatf("%s.m%0d.full", tag, m), 32'(full_w[m]), 32'(mq[m].size() == 5));
      chk($sformatf("%s.m%0d.empty", tag, m), 32'(empty_w[m]), 32'(mq[m].size() == 0));
      chk($sformatf("%s.m%0d.ovf", tag, m), 32'(ovf_w[m]), 32'(m_ovf[m]));
      chk($sformatf("%s.m%0d.unf", tag, m), 32'(unf_w[m]), 32'(m_unf[m]));
      chk($sformatf("%s.m%0d.pend", tag, m), 32'(pend_w[m]), 32'(m_pend));
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [5:0] tpl,
                       input logic [3:0] tpu, input logic clr);
    @(negedge clk);
    op = o; tgt_pl = tpl; tgt_pu = tpu; clr_flags = clr;
    @(posedge clk);
    model_op(o, tpl, tpu, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; op = 3'd0; clr_flags = 0;
    repeat (2) @(negedge clk);
    model_rst();
    check_all("reset");
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1; op = 3'd0; tgt_pl = '0; tgt_pu = '0; clr_flags = 0;
    #2 rst_n = 0;
    #1;
    model_rst();
    check_all("por");
    do_reset();

    // Test 1: LFSR sequence and period
    do_op("inc1", 3'd1, 0, 0, 0); chk("inc1.k", 32'(pc_w[0]), 32'h020);
    do_op("inc2", 3'd1, 0, 0, 0); chk("inc2.k", 32'(pc_w[0]), 32'h030);
    do_op("inc3", 3'd1, 0, 0, 0); chk("inc3.k", 32'(pc_w[0]), 32'h038);
    for (int i = 0; i < 60; i++) do_op("incp", 3'd1, 0, 0, 0);
    chk("period.k", 32'(pc_w[0]), 32'h000);

    // Test 2: CALL / RET
    do_op("sp3", 3'd6, 0, 4'd3, 0);
    do_op("j20", 3'd2, 6'h20, 0, 0);
    do_op("call15", 3'd3, 6'h15, 0, 0);
    chk("call15.k", 32'(pc_w[0]), 32'({4'hF, 6'h15}));
    chk("call15.top.k", 32'(top_w[0]), 32'({4'h3, 6'h30}));
    do_op("ret", 3'd4, 0, 0, 0);
    chk("ret.k", 32'(pc_w[0]), 32'({4'h3, 6'h30}));

    // Test 3: page preload
    do_op("sp2", 3'd6, 0, 4'd2, 0);
    do_op("j05", 3'd2, 6'h05, 0, 0);
    chk("j05.k", 32'(pc_w[0]), 32'({4'h2, 6'h05}));
    do_op("sp7", 3'd6, 0, 4'd7, 0);
    do_op("sp9", 3'd6, 0, 4'd9, 0);
    do_op("call01", 3'd3, 6'h01, 0, 0);
    chk("call01.k", 32'(pc_w[0]), 32'({4'h7, 6'h01}));
    do_op("sp4", 3'd6, 0, 4'd4, 0);
    do_op("incx", 3'd1, 0, 0, 0);
    do_op("j05b", 3'd2, 6'h05, 0, 0);
    chk("j05b.k", 32'(pc_w[0]), 32'({4'h7, 6'h05}));

    // Test 4: overflow policies
    do_reset();
    for (int i = 1; i <= 6; i++) do_op($sformatf("ocall%0d", i), 3'd3, 6'(i * 7), 0, 0);
    chk("ovf0.k", 32'(ovf_w[0]), 32'd1);
    chk("ovf1.k", 32'(ovf_w[1]), 32'd1);
    chk("ocnt.k", 32'(cnt_w[0]), 32'd5);
    for (int i = 1; i <= 6; i++) do_op($sformatf("oret%0d", i), 3'd4, 0, 0, 0);
    chk("uret.pc.k", 32'(pc_w[0]), 32'd0);
    chk("uret.unf.k", 32'(unf_w[1]), 32'd1);

    // Test 5: lock-up escape, RETSK underflow, clear-vs-error
    do_op("clr", 3'd0, 0, 0, 1);
    do_op("j3f", 3'd2, 6'h3F, 0, 0);
    do_op("lock", 3'd1, 0, 0, 0);
    chk("lock.k", 32'(pc_w[0][5:0]), 32'd0);
    do_op("retsk", 3'd5, 0, 0, 0);
    chk("retsk.k", 32'(pc_w[0]), 32'h020);
    do_op("clrunf", 3'd4, 0, 0, 1);
    chk("clrunf.k", 32'(unf_w[0]), 32'd1);

    // Random phase
    for (int i = 0; i < 400; i++)
      do_op("rnd", 3'($urandom_range(0, 7)), 6'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0));

    // Test 6: asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) do_op("acall", 3'd3, 6'(i + 9), 0, 0);
    @(negedge clk);
    op = 3'd3;
    #2 rst_n = 0;
    #1;
    model_rst();
    check_all("async");
    chk("async.pc.k", 32'(pc_w[1]), 32'd0);
    @(negedge clk);
    op = 3'd0;
    rst_n = 1;
    do_op("post", 3'd1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
